addsub_arbiter: RTL and testbench
=================================

Name: addsub_arbiter

Overview:
Round-robin arbiter and sequencer that shares one addSub4 add/subtract datapath between two requesters. It accepts one operation at a time over a req/gnt handshake and registers the operands onto the datapath inputs (av, bv, M). After one settle cycle it captures resultsv/cout, computes signed overflow, and returns the result with a done pulse to the granted requester. It sits between the operand sources (switch logic, test sequencer) and the shared addSub4 plus 7-segment decoder path.

Parameters:
WIDTH, 4, operand/result width; must match the addSub4 instance.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req0  input  1  requester 0 operation request
a0  input  WIDTH  requester 0 operand A
b0  input  WIDTH  requester 0 operand B
sub0  input  1  requester 0 op: 0 = add, 1 = subtract
req1  input  1  requester 1 operation request
a1  input  WIDTH  requester 1 operand A
b1  input  WIDTH  requester 1 operand B
sub1  input  1  requester 1 op select
gnt0  output  1  one-cycle pulse: requester 0 operands accepted
gnt1  output  1  one-cycle pulse: requester 1 operands accepted
done0  output  1  one-cycle pulse: requester 0 result valid
done1  output  1  one-cycle pulse: requester 1 result valid
result_out  output  WIDTH  last captured result
cout_out  output  1  last captured carry-out
ovf_out  output  1  last captured signed overflow
busy  output  1  high when state is not IDLE
av  output  WIDTH  to addSub4 av
bv  output  WIDTH  to addSub4 bv
M  output  1  to addSub4 M
resultsv  input  WIDTH  from addSub4 resultsv
cout  input  1  from addSub4 cout

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-high. All outputs are registered except busy, which is decoded from state.
- Reset values: state = IDLE; av, bv, M, result_out, cout_out, ovf_out = 0; gnt0/1 and done0/1 = 0; last-served pointer = 1, so requester 0 wins the first tie.
- FSM: IDLE -> EXEC -> IDLE.
- IDLE, with any req high at a rising edge:
  - Select the winner: if only one req is high, that requester; if both are high, the requester not equal to the last-served pointer.
  - Register the winner's a/b/sub into av/bv/M.
  - Set that requester's gnt high for the next cycle.
  - Update the pointer to the winner and go to EXEC.
- IDLE, with no req high: hold state. av/bv/M keep their last values.
- EXEC, one cycle (datapath settles on stable av/bv/M). At the next edge:
  - Capture resultsv -> result_out and cout -> cout_out.
  - Capture ovf_out:
    - M = 0: ovf = (av[msb] == bv[msb]) && (resultsv[msb] != av[msb]).
    - M = 1: ovf = (av[msb] != bv[msb]) && (resultsv[msb] != av[msb]).
  - Pulse done for the granted requester and return to IDLE.
- Latency and throughput: gnt is high the cycle after acceptance, and done is high the cycle after gnt. Throughput is one operation per 2 cycles. A new accept is possible at the edge ending the done cycle.
- Request handshake rules:
  - A requester holds req and operands stable until it sees gnt.
  - It must drop req during the gnt cycle. A req still high in the done cycle (state IDLE) is treated as a new request.
- Result hold: result_out, cout_out and ovf_out hold until the next capture. Only one of done0/done1 is ever high in a cycle.
- Req changes during EXEC are ignored. Operands are already latched.
- Both reqs held continuously: grants strictly alternate 0, 1, 0, 1.
- Reset mid-EXEC: the operation is aborted, no done is issued, all outputs clear to reset values, and the pointer returns to 1.

Test Plan:
- Reset, then req0 with a0=3, b0=4, sub0=0 -> gnt0 pulses the next cycle, done0 pulses the cycle after; result_out=7, cout_out=0, ovf_out=0; gnt1/done1 stay 0.
- req1 with a1=5, b1=3, sub1=1 -> M=1 during EXEC; done1 pulses; result_out=2, cout_out=1, ovf_out=0.
- req0 with 7+1 -> result_out=8, ovf_out=1. Then 8-1 (sub) -> result_out=7, ovf_out=1. Then 0-1 -> result_out=F, cout_out=0, ovf_out=0.
- req0 and req1 both raised in the same cycle right after reset and held high for 8 cycles -> grant order 0, 1, 0, 1. Each gnt is followed by its own done, and the other requester's gnt/done stay low.
- Assert reset asynchronously mid-cycle during EXEC of a 6+6 op -> outputs clear immediately and no done pulse appears. After release, req1 alone is granted first.
- Requester keeps req0 high through the done cycle -> a second gnt0 is issued at the edge ending the done cycle (back-to-back ops every 2 cycles).

Source files
------------

// File: rtl/addsub_arbiter_if.sv
// Handshake and datapath bundle for addsub_arbiter.
// slave: arbiter side (requests in, grants/results/datapath drive out).
// master: requesters plus the shared addSub4 datapath.
// Signals:
//   req0/a0/b0/sub0, req1/a1/b1/sub1 : operation requests and operands
//   gnt0/gnt1, done0/done1           : accept and result-valid pulses
//   result_out/cout_out/ovf_out      : last captured result
//   busy                             : arbiter not idle
//   av/bv/M                          : operands and op select to addSub4
//   resultsv/cout                    : sum and carry from addSub4
interface addsub_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             sub0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             sub1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] result_out;
    logic             cout_out;
    logic             ovf_out;
    logic             busy;
    logic [WIDTH-1:0] av;
    logic [WIDTH-1:0] bv;
    logic             M;
    logic [WIDTH-1:0] resultsv;
    logic             cout;

    modport slave (
        input  req0, a0, b0, sub0,
        input  req1, a1, b1, sub1,
        input  resultsv, cout,
        output gnt0, gnt1, done0, done1,
        output result_out, cout_out, ovf_out,
        output busy, av, bv, M
    );

    modport master (
        output req0, a0, b0, sub0,
        output req1, a1, b1, sub1,
        output resultsv, cout,
        input  gnt0, gnt1, done0, done1,
        input  result_out, cout_out, ovf_out,
        input  busy, av, bv, M
    );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin sharing of one addSub4 datapath between two requesters.
// Ports: clk, reset (async, active-high), bus (addsub_arbiter_if.slave).
// Flow: IDLE accepts the winning request and drives av/bv/M, EXEC lets
// the datapath settle for one cycle, then result/carry/overflow are
// captured and done pulses to the requester that was granted.
module addsub_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    addsub_arbiter_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_ptr;
    logic [WIDTH-1:0] r_av;
    logic [WIDTH-1:0] r_bv;
    logic             r_M;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_done0;
    logic             r_done1;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;

    logic             w_pick0;
    logic             w_same;
    logic             w_ovf;

    // Requester 0 wins when alone, or on a tie when 1 was served last.
    assign w_pick0 = bus.req0 & (~bus.req1 | r_ptr);

    // Add overflows on equal operand signs, subtract on differing
    // signs, in both cases only when the result sign flips from av.
    assign w_same = (r_av[MSB] == r_bv[MSB]);
    assign w_ovf  = (r_M ? ~w_same : w_same) &
                    (bus.resultsv[MSB] != r_av[MSB]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_ptr    <= 1'b1;
            r_av     <= '0;
            r_bv     <= '0;
            r_M      <= 1'b0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick0) begin
                        r_av    <= bus.a0;
                        r_bv    <= bus.b0;
                        r_M     <= bus.sub0;
                        r_gnt0  <= 1'b1;
                        r_ptr   <= 1'b0;
                        r_state <= EXEC;
                    end else if (bus.req1) begin
                        r_av    <= bus.a1;
                        r_bv    <= bus.b1;
                        r_M     <= bus.sub1;
                        r_gnt1  <= 1'b1;
                        r_ptr   <= 1'b1;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_result <= bus.resultsv;
                    r_cout   <= bus.cout;
                    r_ovf    <= w_ovf;
                    // The pointer already names the granted requester.
                    r_done0  <= ~r_ptr;
                    r_done1  <= r_ptr;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.av         = r_av;
    assign bus.bv         = r_bv;
    assign bus.M          = r_M;
    assign bus.gnt0       = r_gnt0;
    assign bus.gnt1       = r_gnt1;
    assign bus.done0      = r_done0;
    assign bus.done1      = r_done1;
    assign bus.result_out = r_result;
    assign bus.cout_out   = r_cout;
    assign bus.ovf_out    = r_ovf;
    assign bus.busy       = (r_state == EXEC);
endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter with a behavioural addSub4.
// Table vectors, random ops against an arithmetic model, corner sequences.
module tb_addsub_arbiter;
    logic clk;
    logic reset;
    int   n_err;
    int   n_chk;
    bit   tb_last;

    addsub_arbiter_if #(.WIDTH(4)) bus ();

    addsub_arbiter #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural addSub4: subtract as av + ~bv + 1.
    logic [4:0] w_sum;
    always_comb begin
        w_sum = '0;
        if (bus.M)
            w_sum = {1'b0, bus.av} + {1'b0, ~bus.bv} + 5'd1;
        else
            w_sum = {1'b0, bus.av} + {1'b0, bus.bv};
    end
    assign bus.resultsv = w_sum[3:0];
    assign bus.cout     = w_sum[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rq;
        logic [3:0] a;
        logic [3:0] b;
        bit         sub;
        logic [3:0] res;
        bit         co;
        bit         ov;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Arithmetic reference: {carry, overflow, result}.
    function automatic logic [5:0] ref_op(input int a, input int b,
                                          input bit sub);
        int sa, sb, r, u;
        bit co, ov;
        logic [3:0] res;
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        if (sub) begin
            u  = a - b;
            co = (a >= b);
            r  = sa - sb;
        end else begin
            u  = a + b;
            co = (u > 15);
            r  = sa + sb;
        end
        ov  = (r > 7) || (r < -8);
        res = 4'(u);
        return {co, ov, res};
    endfunction

    function automatic bit winner(input bit r0, input bit r1);
        if (r0 && r1)
            return ~tb_last;
        return r1;
    endfunction

    task automatic run_op(input bit r0, input bit r1,
                          input logic [3:0] ia0, input logic [3:0] ib0,
                          input bit is0,
                          input logic [3:0] ia1, input logic [3:0] ib1,
                          input bit is1,
                          input logic [3:0] er, input bit ec,
                          input bit eo);
        bit w;
        w = winner(r0, r1);
        tb_last = w;
        bus.req0 = r0; bus.a0 = ia0; bus.b0 = ib0; bus.sub0 = is0;
        bus.req1 = r1; bus.a1 = ia1; bus.b1 = ib1; bus.sub1 = is1;
        @(posedge clk); #1;
        check("gnt0", 32'(bus.gnt0), 32'(!w));
        check("gnt1", 32'(bus.gnt1), 32'(w));
        check("busy_exec", 32'(bus.busy), 32'd1);
        check("av", 32'(bus.av), 32'(w ? ia1 : ia0));
        check("bv", 32'(bus.bv), 32'(w ? ib1 : ib0));
        check("M", 32'(bus.M), 32'(w ? is1 : is0));
        check("done_early", 32'({bus.done0, bus.done1}), 32'd0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(posedge clk); #1;
        check("done0", 32'(bus.done0), 32'(!w));
        check("done1", 32'(bus.done1), 32'(w));
        check("gnt_late", 32'({bus.gnt0, bus.gnt1}), 32'd0);
        check("result", 32'(bus.result_out), 32'(er));
        check("cout", 32'(bus.cout_out), 32'(ec));
        check("ovf", 32'(bus.ovf_out), 32'(eo));
        check("busy_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] exp;
        logic [3:0] ra0, rb0, ra1, rb1;
        bit rs0, rs1, r0, r1, w;
        int pat;

        n_err = 0;
        n_chk = 0;
        tbl[0] = '{0, 4'd3, 4'd4, 0, 4'd7, 0, 0};
        tbl[1] = '{1, 4'd5, 4'd3, 1, 4'd2, 1, 0};
        tbl[2] = '{0, 4'd7, 4'd1, 0, 4'd8, 0, 1};
        tbl[3] = '{0, 4'd8, 4'd1, 1, 4'd7, 1, 1};
        tbl[4] = '{0, 4'd0, 4'd1, 1, 4'hF, 0, 0};

        bus.req0 = 0; bus.a0 = 0; bus.b0 = 0; bus.sub0 = 0;
        bus.req1 = 0; bus.a1 = 0; bus.b1 = 0; bus.sub1 = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tb_last = 1'b1;
        check("rst_out", 32'({bus.gnt0, bus.gnt1, bus.done0,
              bus.done1, bus.cout_out, bus.ovf_out, bus.M,
              bus.busy}), 32'd0);
        check("rst_res", 32'({bus.result_out, bus.av, bus.bv}), 32'd0);

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].rq)
                run_op(0, 1, 0, 0, 0, tbl[i].a, tbl[i].b, tbl[i].sub,
                       tbl[i].res, tbl[i].co, tbl[i].ov);
            else
                run_op(1, 0, tbl[i].a, tbl[i].b, tbl[i].sub, 0, 0, 0,
                       tbl[i].res, tbl[i].co, tbl[i].ov);
        end

        for (int i = 0; i < 40; i++) begin
            pat = $urandom_range(2, 0);
            r0  = (pat != 1);
            r1  = (pat != 0);
            ra0 = 4'($urandom_range(15, 0));
            rb0 = 4'($urandom_range(15, 0));
            rs0 = 1'($urandom_range(1, 0));
            ra1 = 4'($urandom_range(15, 0));
            rb1 = 4'($urandom_range(15, 0));
            rs1 = 1'($urandom_range(1, 0));
            w   = winner(r0, r1);
            if (w)
                exp = ref_op(int'(ra1), int'(rb1), rs1);
            else
                exp = ref_op(int'(ra0), int'(rb0), rs0);
            run_op(r0, r1, ra0, rb0, rs0, ra1, rb1, rs1,
                   exp[3:0], exp[5], exp[4]);
        end

        // req0 held through the done cycle: re-accepted back to back.
        bus.req0 = 1; bus.a0 = 4'd2; bus.b0 = 4'd3; bus.sub0 = 0;
        bus.req1 = 0;
        @(posedge clk); #1;
        check("b2b_gnt_a", 32'(bus.gnt0), 32'd1);
        @(posedge clk); #1;
        check("b2b_done_a", 32'(bus.done0), 32'd1);
        check("b2b_res_a", 32'(bus.result_out), 32'd5);
        @(posedge clk); #1;
        check("b2b_gnt_b", 32'(bus.gnt0), 32'd1);
        bus.req0 = 0;
        @(posedge clk); #1;
        check("b2b_done_b", 32'(bus.done0), 32'd1);
        tb_last = 1'b0;

        // Reset in the middle of EXEC for 6+6.
        bus.req0 = 1; bus.a0 = 4'd6; bus.b0 = 4'd6; bus.sub0 = 0;
        @(posedge clk); #1;
        check("mid_gnt", 32'(bus.gnt0), 32'd1);
        check("mid_busy", 32'(bus.busy), 32'd1);
        bus.req0 = 0;
        #2 reset = 1'b1;
        #1;
        check("mid_clr", 32'({bus.gnt0, bus.busy, bus.av, bus.bv,
              bus.result_out, bus.cout_out}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        tb_last = 1'b1;
        @(posedge clk); #1;
        check("mid_nodone", 32'({bus.done0, bus.done1}), 32'd0);
        check("mid_res", 32'(bus.result_out), 32'd0);
        run_op(0, 1, 0, 0, 0, 4'd9, 4'd2, 1, 4'd7, 1, 1);

        // Both held from reset: 0 first, then strict alternation.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        tb_last = 1'b1;
        bus.req0 = 1; bus.a0 = 4'd1; bus.b0 = 4'd1; bus.sub0 = 0;
        bus.req1 = 1; bus.a1 = 4'd9; bus.b1 = 4'd1; bus.sub1 = 1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check("rr_gnt0", 32'(bus.gnt0), 32'(k % 4 == 0));
            check("rr_done0", 32'(bus.done0), 32'(k % 4 == 1));
            check("rr_gnt1", 32'(bus.gnt1), 32'(k % 4 == 2));
            check("rr_done1", 32'(bus.done1), 32'(k % 4 == 3));
            if (k % 4 == 1)
                check("rr_res0", 32'(bus.result_out), 32'd2);
            if (k % 4 == 3)
                check("rr_res1", 32'({bus.cout_out, bus.ovf_out,
                      bus.result_out}), 32'h28);
        end
        bus.req0 = 0;
        bus.req1 = 0;
        @(posedge clk); #1;
        check("rr_stop", 32'({bus.busy, bus.gnt0, bus.gnt1}), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
